// File: rtl/quad_encoder_emulator_pkg.sv
// quad_pkg: types and helpers shared by the quadrature encoder emulator and
// any decoder-side checks.
//   phase_t    : 2-bit Gray phase, bit 1 = a, bit 0 = b
//   state_t    : emulator control states
//   FWD        : direction code for forward motion (a leads b)
//   next_phase : next Gray phase for one quadrature edge in a given direction
package quad_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic FWD = 1'b1;

    // Forward walks 00->10->11->01, reverse walks the same ring backwards.
    function automatic phase_t next_phase(input phase_t ph, input logic dir);
        phase_t n;
        if (dir == FWD) begin
            case (ph)
                2'b00:   n = 2'b10;
                2'b10:   n = 2'b11;
                2'b11:   n = 2'b01;
                default: n = 2'b00;
            endcase
        end else begin
            case (ph)
                2'b00:   n = 2'b01;
                2'b01:   n = 2'b11;
                2'b11:   n = 2'b10;
                default: n = 2'b00;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/quad_encoder_emulator_if.sv
// Command channel of the quadrature encoder emulator.
//   cmd_valid/cmd_ready : handshake, transfer when both high
//   cmd_steps           : number of quadrature edges to emit
//   cmd_dir             : 1 = forward, 0 = reverse
//   cmd_period          : clocks between edges (0 behaves as 1)
//   abort               : stop the running or just-accepted command
// master = command source, slave = emulator.
interface quad_encoder_emulator_if #(
    parameter int STEP_W = 16,
    parameter int PER_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_dir;
    logic [PER_W-1:0]  cmd_period;
    logic              abort;

    modport master (
        output cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
        output cmd_ready
    );
endinterface

// File: rtl/quad_encoder_emulator_edge_timer.sv
// quad_edge_timer: reloadable down-counter that paces quadrature edges.
//   clk, reset : clock, async active-low reset
//   clr        : synchronous clear to 0
//   load       : load load_val (takes priority over counting)
//   load_val   : value loaded on load
//   en         : count down; on expiry reload from period
//   period     : reload value after each expiry
//   tick       : one-cycle pulse in the cycle the count expires
module quad_edge_timer #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    input  logic             en,
    input  logic [PER_W-1:0] period,
    output logic             tick
);
    logic [PER_W-1:0] cnt;

    // Expiry is the cycle holding 1, so a reload of P gives a tick every P clocks.
    assign tick = en && (cnt == PER_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     cnt <= '0;
        else if (clr)   cnt <= '0;
        else if (load)  cnt <= load_val;
        else if (en)    cnt <= tick ? period : cnt - PER_W'(1);
    end
endmodule

// File: rtl/quad_encoder_emulator.sv
// quad_encoder_emulator: turns step commands into registered, Gray-coded
// quadrature a/b waveforms and tracks a signed position.
//   clk, reset : clock, async active-low reset
//   cmd        : command channel (slave side)
//   a, b       : quadrature outputs, straight from the phase flops
//   busy       : command running
//   done       : one-cycle pulse at completion or abort
//   position   : two's-complement edge count, +1 forward / -1 reverse, wraps
module quad_encoder_emulator
    import quad_pkg::*;
#(
    parameter int STEP_W = 16,
    parameter int PER_W  = 16,
    parameter int POS_W  = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    quad_encoder_emulator_if.slave   cmd,
    output logic                     a,
    output logic                     b,
    output logic                     busy,
    output logic                     done,
    output logic [POS_W-1:0]         position
);
    state_t            state, state_nx;
    phase_t            phase;
    logic              dir_q;
    logic [PER_W-1:0]  per_q;
    logic [STEP_W-1:0] rem;
    logic [POS_W-1:0]  pos_q;

    logic              accept;
    logic [PER_W-1:0]  per_eff;
    logic [PER_W-1:0]  first_load;
    logic              first_now;
    logic              tick;
    logic              emit;
    logic              emit_dir;

    assign accept  = cmd.cmd_valid && (state == IDLE);
    assign per_eff = (cmd.cmd_period == '0) ? PER_W'(1) : cmd.cmd_period;

    // Edges are registered, so the edge visible at T+k*P is committed one
    // clock earlier. The first countdown is therefore P-1 long; with P=1 the
    // first edge has to be committed in the accept cycle itself.
    assign first_load = (per_eff == PER_W'(1)) ? PER_W'(1) : per_eff - PER_W'(1);
    assign first_now  = accept && !cmd.abort && (cmd.cmd_steps != '0) &&
                        (per_eff == PER_W'(1));

    quad_edge_timer #(.PER_W(PER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (state == DONE),
        .load     (accept),
        .load_val (first_load),
        .en       ((state == RUN) && (rem != '0)),
        .period   (per_q),
        .tick     (tick)
    );

    assign emit     = first_now || tick;
    assign emit_dir = (state == IDLE) ? cmd.cmd_dir : dir_q;

    always_comb begin
        state_nx      = state;
        cmd.cmd_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (accept)
                    state_nx = (cmd.abort || (cmd.cmd_steps == '0)) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                // rem reaches 0 in the cycle the last edge becomes visible.
                if (cmd.abort || (rem == '0)) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            phase <= 2'b00;
            dir_q <= FWD;
            per_q <= PER_W'(1);
            rem   <= '0;
            pos_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                dir_q <= cmd.cmd_dir;
                per_q <= per_eff;
                rem   <= cmd.cmd_steps - STEP_W'(first_now);
            end else if (state == DONE) begin
                rem <= '0;
            end else if (tick) begin
                rem <= rem - STEP_W'(1);
            end
            if (emit) begin
                phase <= next_phase(phase, emit_dir);
                pos_q <= pos_q + ((emit_dir == FWD) ? POS_W'(1) : {POS_W{1'b1}});
            end
        end
    end

    assign a        = phase[1];
    assign b        = phase[0];
    assign position = pos_q;
endmodule
